controle_senhas: RTL

Sequencing controller for the two-stage password puzzle of the time bomb. It synchronizes the player's ENTER button and judges each attempt against password A (4 bits), then password B (3 bits). It counts wrong attempts and drives the stage flag, hint enable and hint strobe consumed by the correct-bits hint display. It also declares the bomb defused or exploded, and sits between the switch/button inputs, the countdown timer and the hint/display blocks.

---
 rtl/bomba_pkg.sv | 28 ++
 rtl/sincroniza_botao.sv | 32 +++
 rtl/controle_senhas.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bomba_pkg.sv
// Shared types and constants for the bomb password puzzle controller.
package bomba_pkg;

    // State encoding is visible on ESTADO, so the values are fixed.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FASE_A      = 3'd1,
        FASE_B      = 3'd2,
        AVALIA      = 3'd3,
        DESARMADA_S = 3'd4,
        EXPLODIU_S  = 3'd5
    } estado_t;

    localparam int ERROS_MAX_W = 2;

    localparam logic [ERROS_MAX_W-1:0] ERROS_SAT = '1;

    // Error counter increment that sticks at all-ones.
    function automatic logic [ERROS_MAX_W-1:0] incr_sat(input logic [ERROS_MAX_W-1:0] v);
        return (v == ERROS_SAT) ? v : v + ERROS_MAX_W'(1);
    endfunction

    // States in which a password attempt is in progress.
    function automatic logic em_jogo(input estado_t e);
        return (e == FASE_A) || (e == FASE_B) || (e == AVALIA);
    endfunction

endpackage

// File: rtl/sincroniza_botao.sv
// Two-flop synchronizer for an asynchronous push-button followed by a
// rising-edge detector producing a single-cycle pulse per press.
module sincroniza_botao (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_IN,
    output logic PULSO
);

    logic sync_1;
    logic sync_2;
    logic sync_ant;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_ant <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous
            // stage's old value, which is what builds a real shift chain.
            sync_1   <= BTN_IN;
            sync_2   <= sync_1;
            sync_ant <= sync_2;
        end
    end

    // High for exactly one cycle after the synchronized button rises.
    assign PULSO = sync_2 & ~sync_ant;

endmodule

// File: rtl/controle_senhas.sv
// Sequencing controller for the two-stage bomb password puzzle: judges
// attempts against password A then B, counts misses, drives the hint
// handshake and declares the bomb defused or exploded.
module controle_senhas
    import bomba_pkg::*;
#(
    parameter int MAX_ERROS = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic                   ENTER,
    input  logic [3:0]             TENTATIVA,
    input  logic [3:0]             A,
    input  logic [2:0]             B,
    input  logic                   TIMEOUT,
    output logic                   ACERTOU_SENHA_A,
    output logic                   HINT_ENABLE,
    output logic                   HINT_STROBE,
    output logic [ERROS_MAX_W-1:0] ERROS,
    output logic                   DESARMADA,
    output logic                   EXPLODIU,
    output logic [2:0]             ESTADO
);

    localparam logic [ERROS_MAX_W-1:0] LIMITE = ERROS_MAX_W'(MAX_ERROS);

    logic                   ep;

    estado_t                estado_q, estado_d;
    logic [3:0]             tentativa_q;
    logic                   fase_b_q, fase_b_d;
    logic [ERROS_MAX_W-1:0] erros_q, erros_d;
    logic                   acertou_q, acertou_d;
    logic                   strobe_d;
    logic                   captura;
    logic                   hint_enable_q;
    logic                   strobe_q;
    logic                   desarmada_q;
    logic                   explodiu_q;

    logic                   acerto;
    logic [ERROS_MAX_W-1:0] erros_inc;

    sincroniza_botao u_enter (
        .CLK    (CLK),
        .RESET  (RESET),
        .BTN_IN (ENTER),
        .PULSO  (ep)
    );

    // The remembered phase selects which password the captured attempt faces.
    assign acerto    = fase_b_q ? (tentativa_q[2:0] == B) : (tentativa_q == A);
    assign erros_inc = incr_sat(erros_q);

    // Next-state and next-value logic for the whole controller.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        estado_d  = estado_q;
        fase_b_d  = fase_b_q;
        erros_d   = erros_q;
        acertou_d = acertou_q;
        strobe_d  = 1'b0;
        captura   = 1'b0;

        case (estado_q)
            IDLE: begin
                if (START) begin
                    estado_d  = FASE_A;
                    erros_d   = '0;
                    acertou_d = 1'b0;
                end
            end

            FASE_A, FASE_B: begin
                // Timeout wins over a simultaneous press; that press is lost.
                if (TIMEOUT) begin
                    estado_d = EXPLODIU_S;
                end else if (ep) begin
                    captura  = 1'b1;
                    strobe_d = 1'b1;
                    fase_b_d = (estado_q == FASE_B);
                    estado_d = AVALIA;
                end
            end

            AVALIA: begin
                if (acerto) begin
                    if (fase_b_q) begin
                        estado_d = DESARMADA_S;
                    end else begin
                        estado_d  = FASE_B;
                        acertou_d = 1'b1;
                    end
                end else begin
                    erros_d = erros_inc;
                    if (erros_inc == LIMITE) begin
                        estado_d = EXPLODIU_S;
                    end else begin
                        estado_d = fase_b_q ? FASE_B : FASE_A;
                    end
                end
            end

            DESARMADA_S, EXPLODIU_S: begin
                if (START) begin
                    estado_d  = FASE_A;
                    erros_d   = '0;
                    acertou_d = 1'b0;
                end
            end

            default: estado_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs, all computed from next values
    // so every output lines up with the state it describes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            estado_q      <= IDLE;
            tentativa_q   <= '0;
            fase_b_q      <= 1'b0;
            erros_q       <= '0;
            acertou_q     <= 1'b0;
            strobe_q      <= 1'b0;
            hint_enable_q <= 1'b0;
            desarmada_q   <= 1'b0;
            explodiu_q    <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            if (captura) begin
                tentativa_q <= TENTATIVA;
            end
            fase_b_q      <= fase_b_d;
            erros_q       <= erros_d;
            acertou_q     <= acertou_d;
            strobe_q      <= strobe_d;
            hint_enable_q <= em_jogo(estado_d) && (erros_d != '0);
            desarmada_q   <= (estado_d == DESARMADA_S);
            explodiu_q    <= (estado_d == EXPLODIU_S);
        end
    end

    assign ESTADO          = estado_q;
    assign ERROS           = erros_q;
    assign ACERTOU_SENHA_A = acertou_q;
    assign HINT_STROBE     = strobe_q;
    assign HINT_ENABLE     = hint_enable_q;
    assign DESARMADA       = desarmada_q;
    assign EXPLODIU        = explodiu_q;

endmodule
